lcd_result_formatter: RTL and testbench
=======================================

Name: lcd_result_formatter

Overview:
Sits between the ALU result mux and the LCD character driver. Watches the 8-bit ALU result and, on each new value, converts it to unsigned decimal with a sequential double-dabble. It then streams the ASCII characters, each tagged with a target column, over a valid/ready handshake. This lets the LCD driver accept pre-formatted characters instead of raw binary.

Parameters:
START_COL, 0, LCD column (0-15) of the first emitted character.
BLANK_LZ, 1, 1 = leading zeros of the decimal field replaced by space (0x20); the units digit is always shown.

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-high reset
data_in  input  8  ALU result to display, unsigned
char_out  output  8  ASCII character
char_pos  output  4  LCD column for char_out
char_valid  output  1  char_out/char_pos valid
char_ready  input  1  downstream accepts the character this cycle
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse after the last character is accepted

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high.
  - While rst is high: all outputs 0, state IDLE, last_val 0, first flag set.
  - Reset mid-operation aborts immediately; char_valid drops asynchronously; no frame_done.
- States: IDLE -> CONVERT -> EMIT -> IDLE.
- IDLE:
  - Triggers when (data_in != last_val) or first flag is set.
  - On a triggering edge: latch data_in into val, clear BCD, go to CONVERT.
- CONVERT:
  - 8 cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,val} left 1.
  - Then load character index 0 and go to EMIT.
  - char_valid first asserts on the 9th rising edge after the capturing edge.
- EMIT:
  - Characters in order: hundreds, tens, units. Digit = 0x30 + nibble.
  - With BLANK_LZ: hundreds = 0x20 if 0; tens = 0x20 if hundreds and tens are both 0.
  - char_pos = START_COL + index, modulo 16 (wraps at 15 -> 0).
- Handshake:
  - Transfer occurs when char_valid and char_ready are both high on a rising edge.
  - While char_valid=1 and char_ready=0, char_out and char_pos hold stable; char_valid never deasserts without a transfer (except reset).
  - Consecutive transfers on back-to-back cycles are supported: one character per cycle.
- Frame end: on transfer of the last character:
  - char_valid=0, frame_done=1 for exactly one cycle.
  - last_val <= val, first flag cleared, return to IDLE.
- data_in changes while busy: ignored. The value is compared against last_val in IDLE, so only the latest value is displayed; no queue.
- A change to a value equal to last_val causes no frame.
- The first frame after reset is always emitted, including for value 0.

Optional Feature:
LCD_FMT_HEX_EN
- Defined: after the units digit, emit 5 more characters: space, '0', 'x', hex high nibble, hex low nibble. Hex digits are uppercase (0x41-0x46 for A-F); columns continue incrementing. Frame is 8 characters.
- Undefined: frame is 3 characters; no hex logic is synthesised.

Decomposition:
- Package lcd_fmt_pkg holds:
  - state enum {IDLE, CONVERT, EMIT}
  - ASCII_ZERO=8'h30, ASCII_SPACE=8'h20, ASCII_X=8'h78, ASCII_A=8'h41
  - DEC_CHARS=3, HEX_CHARS=5
  - hex-to-ASCII function
- Sub-module bin2bcd8: sequential double-dabble with start/done handshake, 8-bit in, 12-bit BCD out. Instantiated once.

Test Plan:
- After reset, data_in=0xFF, char_ready=1 -> chars "2","5","5" (0x32,0x35,0x35) at cols 0,1,2; one frame_done pulse; no further frame while data_in holds.
- data_in=0x07, BLANK_LZ=1 -> 0x20,0x20,0x37. With BLANK_LZ=0 -> 0x30,0x30,0x37. Immediately after reset, data_in=0x00 -> 0x20,0x20,0x30.
- data_in=0x80, char_ready low for 5 cycles on the 2nd character -> char_out held at 0x32 with char_valid high throughout; then "8" accepted; frame completes.
- Change data_in 0x10 -> 0x20 -> 0x30 during CONVERT of 0x10 -> frame "16", then one frame "48"; no frame for 0x20.
- Assert rst mid-EMIT -> char_valid, busy, frame_done are 0 while rst is high; after release, current data_in is re-emitted.
- With LCD_FMT_HEX_EN, START_COL=12, data_in=0xA5 -> "165 0xA5"; columns 12,13,14,15,0,1,2,3.

Source files
------------

// File: rtl/lcd_fmt_pkg.sv
// Shared types, ASCII constants and helpers for the LCD result formatter.
// No ports. Frame layout is decimal (DEC_CHARS) optionally followed by a
// hex suffix (HEX_CHARS) when LCD_FMT_HEX_EN is defined.
package lcd_fmt_pkg;

   typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_X     = 8'h78;
   localparam logic [7:0] ASCII_A     = 8'h41;

   localparam int DEC_CHARS = 3;
   localparam int HEX_CHARS = 5;

   // Uppercase hex digit
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return ASCII_ZERO + {4'd0, nib};
      else             return ASCII_A + {4'd0, nib} - 8'd10;
   endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD in 8 shift cycles.
// Ports:
//   clk, rst  : clock, async active-high reset
//   start     : load bin and begin conversion (one-cycle pulse)
//   bin [7:0] : value to convert
//   bcd [11:0]: {hundreds, tens, units}; stable after done until next start
//   done      : high for one cycle once all 8 shifts are complete
module bin2bcd8 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic [11:0] bcd,
   output logic        done
);

   logic [7:0]  shreg;
   logic [3:0]  cnt;
   logic        running;
   logic [11:0] adj;

   always_comb begin
      adj = bcd;
      for (int n = 0; n < 3; n++) begin
         if (bcd[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         bcd     <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (start) begin
         shreg   <= bin;
         bcd     <= '0;
         cnt     <= 4'd8;
         running <= 1'b1;
      end else if (running) begin
         if (cnt == 4'd0) begin
            running <= 1'b0;
         end else begin
            {bcd, shreg} <= {adj[10:0], shreg, 1'b0};
            cnt          <= cnt - 4'd1;
         end
      end
   end

   // Down-counter terminal count marks the last shift as applied
   assign done = running && (cnt == 4'd0);

endmodule

// File: rtl/lcd_result_formatter.sv
// Converts each new 8-bit ALU result to decimal ASCII and streams the
// characters, tagged with an LCD column, over a valid/ready handshake.
// Optional macro LCD_FMT_HEX_EN appends " 0xHH" to each frame.
// Parameters: START_COL (first column, 0-15), BLANK_LZ (blank leading zeros).
// Ports:
//   clk, rst       : clock, async active-high reset
//   data_in [7:0]  : ALU result, unsigned
//   char_out [7:0] : ASCII character
//   char_pos [3:0] : LCD column for char_out
//   char_valid     : char_out/char_pos valid
//   char_ready     : downstream accepts this cycle
//   busy           : high outside IDLE
//   frame_done     : one-cycle pulse after the last character is accepted
//
// state   | meaning
// IDLE    | waiting for data_in != last_val (or first frame after reset)
// CONVERT | double-dabble running in bin2bcd8
// EMIT    | presenting characters, one per accepted transfer
module lcd_result_formatter #(
   parameter int START_COL = 0,
   parameter bit BLANK_LZ  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   output logic [7:0] char_out,
   output logic [3:0] char_pos,
   output logic       char_valid,
   input  logic       char_ready,
   output logic       busy,
   output logic       frame_done
);
   import lcd_fmt_pkg::*;

`ifdef LCD_FMT_HEX_EN
   localparam int FRAME_CHARS = DEC_CHARS + HEX_CHARS;
`else
   localparam int FRAME_CHARS = DEC_CHARS;
`endif
   localparam logic [2:0] LAST_IDX = 3'(FRAME_CHARS - 1);

   state_t      state, state_nx;
   logic [7:0]  val, last_val;
   logic        first;
   logic [2:0]  idx;
   logic [11:0] bcd;
   logic        conv_done;
   logic        trigger, start, xfer, last_xfer;
   logic [3:0]  hund, tens, units;

   assign trigger   = (data_in != last_val) || first;
   assign start     = (state == IDLE) && trigger;
   assign xfer      = char_valid && char_ready;
   assign last_xfer = xfer && (idx == LAST_IDX);

   bin2bcd8 u_bin2bcd8 (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (data_in),
      .bcd   (bcd),
      .done  (conv_done)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (trigger)   state_nx = CONVERT;
         CONVERT: if (conv_done) state_nx = EMIT;
         EMIT:    if (last_xfer) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         val        <= '0;
         last_val   <= '0;
         first      <= 1'b1;
         idx        <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         frame_done <= 1'b0;
         if (start) val <= data_in;
         if (state == CONVERT) idx <= '0;
         if (state == EMIT && xfer) begin
            if (last_xfer) begin
               frame_done <= 1'b1;
               last_val   <= val;
               first      <= 1'b0;
            end else begin
               idx <= idx + 3'd1;
            end
         end
      end
   end

   assign char_valid = (state == EMIT);
   assign busy       = (state != IDLE);
   assign char_pos   = char_valid ? 4'(START_COL) + {1'b0, idx} : 4'd0;

   assign hund  = bcd[11:8];
   assign tens  = bcd[7:4];
   assign units = bcd[3:0];

   always_comb begin
      char_out = 8'h00;
      if (char_valid) begin
         case (idx)
            3'd0: char_out = (BLANK_LZ && hund == 4'd0) ? ASCII_SPACE
                                                         : ASCII_ZERO + {4'd0, hund};
            3'd1: char_out = (BLANK_LZ && hund == 4'd0 && tens == 4'd0) ? ASCII_SPACE
                                                         : ASCII_ZERO + {4'd0, tens};
            3'd2: char_out = ASCII_ZERO + {4'd0, units};
`ifdef LCD_FMT_HEX_EN
            3'd3: char_out = ASCII_SPACE;
            3'd4: char_out = ASCII_ZERO;
            3'd5: char_out = ASCII_X;
            3'd6: char_out = hex_ascii(val[7:4]);
            3'd7: char_out = hex_ascii(val[3:0]);
`endif
            default: char_out = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_result_formatter.sv
// Directed bench for lcd_result_formatter. Two instances share stimulus:
// u_dut uses defaults (col 0, blanking), u_dut_z uses col 14 without
// blanking so column wrap and zero-padded digits are seen on every frame.
module tb_lcd_result_formatter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'hFF;
   logic       char_ready = 1'b1;

   logic [7:0] char_out, char_out_z;
   logic [3:0] char_pos, char_pos_z;
   logic       char_valid, char_valid_z, busy, busy_z, frame_done, frame_done_z;

   int n_checks = 0;
   int n_pass   = 0;

   always #10 clk = ~clk;

   lcd_result_formatter u_dut (
      .clk(clk), .rst(rst), .data_in(data_in),
      .char_out(char_out), .char_pos(char_pos), .char_valid(char_valid),
      .char_ready(char_ready), .busy(busy), .frame_done(frame_done)
   );

   lcd_result_formatter #(.START_COL(14), .BLANK_LZ(0)) u_dut_z (
      .clk(clk), .rst(rst), .data_in(data_in),
      .char_out(char_out_z), .char_pos(char_pos_z), .char_valid(char_valid_z),
      .char_ready(char_ready), .busy(busy_z), .frame_done(frame_done_z)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // Consume one frame with char_ready high (optionally stalling one char)
   task automatic expect_frame(input string tag, input string sa, input string sb,
                               input string hx, input int latency, input int stall_idx);
      string fa, fb;
      int    waited;
      fa = sa;
      fb = sb;
`ifdef LCD_FMT_HEX_EN
      fa = {sa, hx};
      fb = {sb, hx};
`else
      if (hx.len() == 0) fa = sa;
`endif
      for (int i = 0; i < fa.len(); i++) begin
         waited = 0;
         while (!char_valid && waited < 40) begin
            @(negedge clk);
            waited++;
         end
         if (!char_valid) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
            return;
         end
         if (i == 0 && latency >= 0) check({tag, " latency"}, 32'(waited), 32'(latency));
         if (i == stall_idx) begin
            char_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check({tag, " hold char"}, 32'(char_out), 32'(fa[i]));
               check({tag, " hold valid"}, 32'(char_valid), 32'd1);
            end
            char_ready = 1'b1;
         end
         check({tag, $sformatf(" char%0d", i)}, 32'(char_out), 32'(fa[i]));
         check({tag, $sformatf(" pos%0d", i)}, 32'(char_pos), 32'(i % 16));
         check({tag, $sformatf(" zchar%0d", i)}, 32'(char_out_z), 32'(fb[i]));
         check({tag, $sformatf(" zpos%0d", i)}, 32'(char_pos_z), 32'((14 + i) % 16));
         @(negedge clk);
      end
      check({tag, " frame_done"}, 32'(frame_done), 32'd1);
      check({tag, " valid after"}, 32'(char_valid), 32'd0);
      @(negedge clk);
      check({tag, " frame_done pulse"}, 32'(frame_done), 32'd0);
   endtask

   task automatic idle_quiet(input string tag, input int n);
      int cnt;
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (busy || char_valid || frame_done) cnt++;
      end
      check(tag, 32'(cnt), 32'd0);
   endtask

   initial begin
      int w;
      repeat (3) @(negedge clk);
      check("rst valid", 32'(char_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(frame_done), 32'd0);
      check("rst char", 32'(char_out), 32'd0);
      check("rst pos", 32'(char_pos), 32'd0);
      rst = 1'b0;
      expect_frame("ff", "255", "255", " 0xFF", 10, -1);
      idle_quiet("ff quiet", 20);

      data_in = 8'h07;
      expect_frame("07", "  7", "007", " 0x07", 10, -1);

      data_in = 8'h80;
      expect_frame("80", "128", "128", " 0x80", -1, 1);

      data_in = 8'h10;
      repeat (3) @(negedge clk);
      data_in = 8'h20;
      repeat (2) @(negedge clk);
      data_in = 8'h30;
      expect_frame("10", " 16", "016", " 0x10", -1, -1);
      expect_frame("30", " 48", "048", " 0x30", -1, -1);
      idle_quiet("30 quiet", 20);

      data_in = 8'hA5;
      expect_frame("a5", "165", "165", " 0xA5", -1, -1);

      // Reset in the middle of EMIT
      data_in = 8'hC8;
      w = 0;
      while (!char_valid && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("c8 emit start", 32'(char_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort valid", 32'(char_valid), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(frame_done), 32'd0);
      repeat (3) @(negedge clk);
      check("abort done hold", 32'(frame_done), 32'd0);
      check("abort valid hold", 32'(char_valid), 32'd0);
      rst = 1'b0;
      expect_frame("c8", "200", "200", " 0xC8", 10, -1);

      rst = 1'b1;
      data_in = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      expect_frame("00", "  0", "000", " 0x00", 10, -1);
      idle_quiet("00 quiet", 20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
